ifm_fetch_ctrl: RTL and testbench

//  Sequences one IFM tile from an AXI-stream source into the width-converting parser.

---
 rtl/ifm_fetch_ctrl_pkg.sv | 15 +
 rtl/ifm_skid_fifo.sv | 71 +++++++
 rtl/ifm_fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ifm_fetch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_fetch_ctrl_pkg.sv
// Shared definitions for the IFM fetch controller: FSM state encoding and
// the default counter/config field width.
package ifm_fetch_ctrl_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/ifm_skid_fifo.sv
// Two-entry FIFO holding stream words ahead of the parser. Slot 0 is always
// the head, so the head word comes straight off a register with no muxing.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             drop all contents (data zeroed so the head reads 0)
//   push, din       write a word (ignored when full unless popping)
//   pop             remove the head (ignored when empty)
//   head, head_v    head word and its valid flag
//   second_v        a second word is queued behind the head
//   full            both slots occupied
module ifm_skid_fifo #(
  parameter int W = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         head_v,
  output logic         second_v,
  output logic         full
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign head     = slot0;
  assign head_v   = (count != 2'd0);
  assign second_v = (count == 2'd2);
  assign full     = second_v;

  assign do_pop  = pop & head_v;
  assign do_push = push & (!full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever
          // remains after the head leaves.
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifm_fetch_ctrl.sv
// IFM tile fetch controller. Accepts IN_W-bit stream words into a 2-entry
// FIFO, presents the head word to the width-converting parser, drives the
// parser's ifm_read/stall pair, counts output beats and signals tile end.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_start                tile start pulse (only honoured in IDLE)
//   cfg_words, cfg_beats     stream words / parser output beats in the tile
//   s_axis_tdata/tvalid/tlast/tready   input stream
//   fm                       FIFO head word to the parser
//   ifm_read, stall          parser enable / hold
//   input_req                parser has consumed fm, advance next cycle
//   parser_rst               one-cycle parser realign pulse at tile start
//   out_ready, out_valid     downstream acceptance / parser output valid
//   busy, done               not idle / one-cycle tile-complete pulse
//   err_last                 sticky tlast vs word-count mismatch
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for cfg_start
// FILL  | collecting the first word; parser not yet enabled
// RUN   | parser enabled, beats counted, FIFO popped on input_req
// FLUSH | beats complete; FIFO cleared, remaining stream words drained
// DONE  | done pulse, back to IDLE
module ifm_fetch_ctrl
  import ifm_fetch_ctrl_pkg::*;
#(
  parameter int IN_W  = 512,
  parameter int OUT_W = 56,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_words,
  input  logic [CNT_W-1:0] cfg_beats,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [IN_W-1:0]  fm,
  output logic             ifm_read,
  output logic             stall,
  input  logic             input_req,
  output logic             parser_rst,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err_last
);

  if (OUT_W <= 0) begin : g_bad_out_w
    $error("ifm_fetch_ctrl: OUT_W must be positive");
  end

  fetch_state_t state, state_nxt;

  logic [CNT_W-1:0] cfg_words_q;
  logic [CNT_W-1:0] cfg_beats_q;
  logic [CNT_W-1:0] words_rcvd;
  logic [CNT_W-1:0] words_popped;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] last_idx;

  logic fifo_full;
  logic head_v;
  logic second_v;
  logic fifo_clr;
  logic pop;
  logic push;
  logic accept;
  logic start_tile;
  logic head_is_last;
  logic accepting_state;

  assign last_idx        = cfg_words_q - CNT_W'(1);
  assign accepting_state = (state == ST_FILL) || (state == ST_RUN) || (state == ST_FLUSH);
  assign s_axis_tready   = !fifo_full && (words_rcvd < cfg_words_q) && accepting_state;
  assign accept          = s_axis_tvalid & s_axis_tready;
  // Words arriving after the last beat are drained, never stored.
  assign push            = accept && (state != ST_FLUSH);
  // The head's word index equals the number of words already popped.
  assign head_is_last    = (words_popped == last_idx);
  assign busy            = (state != ST_IDLE);

  ifm_skid_fifo #(.W(IN_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (fifo_clr),
    .push     (push),
    .din      (s_axis_tdata),
    .pop      (pop),
    .head     (fm),
    .head_v   (head_v),
    .second_v (second_v),
    .full     (fifo_full)
  );

  always_comb begin
    state_nxt  = state;
    ifm_read   = 1'b0;
    stall      = 1'b0;
    out_valid  = 1'b0;
    pop        = 1'b0;
    fifo_clr   = 1'b0;
    done       = 1'b0;
    start_tile = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          start_tile = 1'b1;
          if ((cfg_words == '0) || (cfg_beats == '0)) state_nxt = ST_DONE;
          else                                        state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (head_v) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ifm_read = 1'b1;
        // A beat that finishes the head word straddles into the next one,
        // so it may only proceed once that word is already queued.
        stall     = !head_v || !out_ready || (input_req && !head_is_last && !second_v);
        out_valid = !stall;
        pop       = input_req && !stall;
        if (out_valid && (beat_cnt == cfg_beats_q - CNT_W'(1))) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        fifo_clr = 1'b1;
        if (words_rcvd == cfg_words_q) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cfg_words_q  <= '0;
      cfg_beats_q  <= '0;
      words_rcvd   <= '0;
      words_popped <= '0;
      beat_cnt     <= '0;
      err_last     <= 1'b0;
      parser_rst   <= 1'b0;
    end else begin
      state      <= state_nxt;
      parser_rst <= start_tile;
      if (start_tile) begin
        cfg_words_q  <= cfg_words;
        cfg_beats_q  <= cfg_beats;
        words_rcvd   <= '0;
        words_popped <= '0;
        beat_cnt     <= '0;
        err_last     <= 1'b0;
      end else begin
        if (accept) begin
          words_rcvd <= words_rcvd + CNT_W'(1);
          if (s_axis_tlast != (words_rcvd == last_idx)) err_last <= 1'b1;
        end
        if (pop)       words_popped <= words_popped + CNT_W'(1);
        if (out_valid) beat_cnt     <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
module tb_ifm_fetch_ctrl;

  localparam int IN_W  = 512;
  localparam int OUT_W = 56;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start;
  logic [CNT_W-1:0] cfg_words;
  logic [CNT_W-1:0] cfg_beats;
  logic [IN_W-1:0]  s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tlast;
  logic             s_axis_tready;
  logic [IN_W-1:0]  fm;
  logic             ifm_read;
  logic             stall;
  logic             input_req;
  logic             parser_rst;
  logic             out_ready;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             err_last;

  always #5 clk = ~clk;

  ifm_fetch_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_words     (cfg_words),
    .cfg_beats     (cfg_beats),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .fm            (fm),
    .ifm_read      (ifm_read),
    .stall         (stall),
    .input_req     (input_req),
    .parser_rst    (parser_rst),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .busy          (busy),
    .done          (done),
    .err_last      (err_last)
  );

  typedef struct {
    int beats;
    int pops;
    bit err;
  } tile_exp_t;

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [IN_W-1:0] exp_q[$];
  tile_exp_t       tile_q[$];
  logic [IN_W-1:0] words[0:15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ..%016h expected ..%016h", name, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] w;
    for (int j = 0; j < IN_W / 32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  // Monitor: compares fm against the scoreboard whenever a beat is emitted
  // and checks per-tile totals when done is presented.
  initial begin : monitor
    int        mon_beats;
    int        mon_pops;
    bit        prev_done;
    tile_exp_t te;
    mon_beats = 0;
    mon_pops  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        mon_beats = 0;
        mon_pops  = 0;
      end else begin
        if (out_valid) begin
          mon_beats++;
          chk("beat_without_ready", {63'd0, out_ready}, 64'd1);
          if (exp_q.size() == 0) begin
            chk("fm_no_word_expected", 64'd1, 64'd0);
          end else begin
            chk_word("fm_head", fm, exp_q[0]);
            if (input_req) begin
              void'(exp_q.pop_front());
              mon_pops++;
            end
          end
        end
        if (ifm_read && !out_ready) begin
          chk("stall_on_backpressure", {63'd0, stall}, 64'd1);
          chk("valid_on_backpressure", {63'd0, out_valid}, 64'd0);
        end
        if (done) begin
          chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
          if (tile_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            te = tile_q.pop_front();
            chk("tile_beats", 64'(mon_beats), 64'(te.beats));
            chk("tile_pops", 64'(mon_pops), 64'(te.pops));
            chk("tile_err_last", {63'd0, err_last}, {63'd0, te.err});
          end
          mon_beats = 0;
          mon_pops  = 0;
          exp_q.delete();
        end
      end
      prev_done = done;
    end
  end

  // smode: 0 continuous, 1 one-on/three-off, 2 random
  // rmode: 0 always ready, 1 five-cycle backpressure window, 2 random
  task automatic run_tile(input int nw, input int nb, input int smode, input int rmode,
                          input int tpos, input bit poke, input int abort_at);
    int  k = 0;
    int  h = 0;
    int  src = 0;
    int  cyc = 0;
    int  run_cyc = 0;
    int  tready_hits = 0;
    bit  finished = 1'b0;
    bit  rst_issued = 1'b0;
    bit  acc, beat, popd;
    bit  zero_cfg;
    bit  want;
    tile_exp_t te;

    zero_cfg = (nw == 0) || (nb == 0);
    for (int i = 0; i < 16; i++) words[i] = rand_word();
    te.beats = zero_cfg ? 0 : nb;
    te.pops  = zero_cfg ? 0 : (nb * OUT_W) / IN_W;
    te.err   = !zero_cfg && (tpos != nw - 1);
    if (abort_at == 0) tile_q.push_back(te);

    @(posedge clk); #1;
    cfg_start     = 1'b1;
    cfg_words     = CNT_W'(nw);
    cfg_beats     = CNT_W'(nb);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    input_req     = 1'b0;
    out_ready     = 1'b1;

    while (!finished && cyc < 3000) begin
      @(negedge clk);
      if (rst_issued && !rst) begin
        chk("rst_outputs", {56'd0, s_axis_tready, ifm_read, stall, parser_rst,
                            out_valid, busy, done, err_last}, 64'd0);
        chk_word("rst_fm", fm, '0);
        exp_q.delete();
        finished = 1'b1;
      end else begin
        if (done) begin
          finished = 1'b1;
          if (zero_cfg) chk("zero_done_latency", 64'(cyc), 64'd1);
        end
        chk("parser_rst_pulse", {63'd0, parser_rst}, {63'd0, (cyc == 1)});
        acc  = s_axis_tvalid && s_axis_tready && !rst;
        beat = out_valid;
        popd = out_valid && input_req;
        if (zero_cfg && s_axis_tready) tready_hits++;
      end
      @(posedge clk); #1;
      cfg_start = 1'b0;
      rst       = 1'b0;
      if (finished) break;
      if (acc) begin
        exp_q.push_back(words[src]);
        src++;
      end
      if (beat) k++;
      if (popd) h++;
      if (ifm_read) run_cyc++;
      cyc++;
      // Source holds a presented word until it is taken.
      case (smode)
        0:       want = 1'b1;
        1:       want = (cyc % 4 == 0);
        default: want = ($urandom_range(0, 2) != 0);
      endcase
      if (s_axis_tvalid && !acc) want = 1'b1;
      s_axis_tvalid = (src < nw) && want;
      s_axis_tdata  = (src < 16) ? words[src] : '0;
      s_axis_tlast  = (src == tpos);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(run_cyc >= 20 && run_cyc < 25);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      // Parser model: each beat consumes OUT_W bits; the beat whose end
      // reaches the end of the current word requests the next one.
      input_req = (OUT_W * (k + 1) >= IN_W * (h + 1));
      if (poke && k == 20) begin
        cfg_start = 1'b1;
        cfg_words = CNT_W'(3);
        cfg_beats = CNT_W'(2);
      end
      if (abort_at > 0 && k == abort_at && !rst_issued) begin
        rst        = 1'b1;
        rst_issued = 1'b1;
      end
    end

    if (!finished) chk("tile_timeout", 64'd0, 64'd1);
    s_axis_tvalid = 1'b0;
    input_req     = 1'b0;
    if (abort_at == 0) begin
      chk("words_taken", 64'(src), zero_cfg ? 64'd0 : 64'(nw));
      if (zero_cfg) chk("zero_tready", 64'(tready_hits), 64'd0);
      @(negedge clk);
      chk("idle_after_done", {58'd0, busy, s_axis_tready, ifm_read, stall, out_valid, done}, 64'd0);
    end
  endtask

  initial begin : stimulus
    int nb, nw;
    rst           = 1'b1;
    cfg_start     = 1'b0;
    cfg_words     = '0;
    cfg_beats     = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    input_req     = 1'b0;
    out_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", {56'd0, s_axis_tready, ifm_read, stall, parser_rst,
                          out_valid, busy, done, err_last}, 64'd0);
    chk_word("reset_fm", fm, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_tile(7, 64, 0, 0, 6, 1'b0, 0);   // nominal
    run_tile(7, 64, 1, 0, 6, 1'b0, 0);   // source gaps
    run_tile(7, 64, 0, 1, 6, 1'b0, 0);   // backpressure window
    run_tile(8, 64, 0, 0, 7, 1'b0, 0);   // extra word drained in FLUSH
    run_tile(7, 64, 0, 0, 4, 1'b0, 0);   // early tlast
    chk("err_last_sticky", {63'd0, err_last}, 64'd1);
    run_tile(7, 0, 0, 0, 6, 1'b0, 0);    // zero beats, also clears err_last
    run_tile(0, 5, 0, 0, 0, 1'b0, 0);    // zero words
    run_tile(7, 64, 0, 0, 6, 1'b0, 10);  // reset mid-RUN
    run_tile(7, 64, 0, 2, 6, 1'b1, 0);   // cfg_start while busy is ignored
    for (int t = 0; t < 5; t++) begin
      nb = $urandom_range(1, 90);
      nw = (nb * OUT_W + IN_W - 1) / IN_W + $urandom_range(0, 1);
      run_tile(nw, nb, 2, 2, nw - 1, 1'b0, 0);
    end
    chk("tiles_all_done", 64'(tile_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
